// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_zero_div;
  logic             w_last;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_a_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_zero_div = (divisor == '0);
  assign w_last     = (r_cnt == '0);

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign w_shifted = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_m};

  always_comb begin
    w_a_next = w_trial;
    w_q_next = {r_q[WIDTH-2:0], 1'b1};
    if (w_trial[WIDTH]) begin
      w_a_next = w_shifted;
      w_q_next = {r_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = w_zero_div ? S_DONE : S_ITER;
      S_ITER: if (w_last) w_state_next = S_DONE;
      S_DONE: begin
        if (start) w_state_next = w_zero_div ? S_DONE : S_ITER;
        else       w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a           <= '0;
      r_q           <= '0;
      r_m           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (w_zero_div) begin
        r_quotient    <= '1;
        r_remainder   <= dividend;
        r_div_by_zero <= 1'b1;
      end else begin
        r_a   <= '0;
        r_q   <= dividend;
        r_m   <= divisor;
        r_cnt <= CW'(WIDTH - 1);
      end
    end else if (r_state == S_ITER) begin
      r_a <= w_a_next;
      r_q <= w_q_next;
      if (w_last) begin
        r_quotient    <= w_q_next;
        r_remainder   <= w_a_next[WIDTH-1:0];
        r_div_by_zero <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign busy        = (r_state == S_ITER);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
